ks_memory: RTL
==============

# ks_memory

Unified 32 × 16-bit program/data memory for the K&S processor: the responder on the datapath's memory interface, serving `ram_addr`/`data_out` reads and writes. It owns a boot loader that accepts the program image from a host over a valid/ready stream. It holds the processor in reset-equivalent idle (`cpu_run` low) until the last word is stored. It then serves processor accesses with a fixed one-cycle read latency.

## Interface
Parameters:
- `DEPTH`, 32: number of words; must equal 2**`ADDR_W`.
- `ADDR_W`, 5: address width, matches datapath `ram_addr`.
- `DATA_W`, 16: word width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ram_addr`  in  ADDR_W  processor address.
- `ram_wdata`  in  DATA_W  processor write data (driven by datapath `data_out`).
- `ram_write_enable`  in  1  processor write strobe.
- `ram_rdata`  out  DATA_W  read data to datapath `data_in`.
- `load_valid`  in  1  host word valid.
- `load_data`  in  DATA_W  host word.
- `load_last`  in  1  marks final word of image.
- `load_ready`  out  1  loader can accept a word.
- `cpu_run`  out  1  image loaded; processor may run.
- `prog_len`  out  ADDR_W+1  number of words loaded (0..32).
- `prot_fault`  out  1  sticky protection fault (only with `KS_MEM_PROTECT_EN`).

## Operation
- FSM states: LOAD, RUN. Reset enters LOAD. RUN exits only through reset.
- LOAD:
  - `load_ready`=1.
  - On `load_valid && load_ready`: `load_data` is written at `load_ptr`, `load_ptr` increments, and `prog_len` increments.
  - Transition to RUN on an accepted beat with `load_last`=1, or with `load_ptr`=31 (array full; `load_last` is implied).
  - Processor writes are ignored. `ram_rdata` holds 0.
- RUN:
  - `load_ready`=0; `load_valid` is ignored.
  - A write with `ram_write_enable`=1 stores `ram_wdata` at `ram_addr`.
  - Every cycle, `ram_rdata` registers `mem[ram_addr]`.
- Read/write to the same address in the same cycle: read-first. `ram_rdata` returns the old word; the new word is visible one cycle later.
- Addresses are a full ADDR_W range, so there is no out-of-range case. `load_ptr` never wraps, because the array-full rule forces RUN.

## Timing
- Reset values:
  - state=LOAD, `load_ptr`=0, `prog_len`=0.
  - `ram_rdata`=0, `cpu_run`=0, `prot_fault`=0.
  - `load_ready`=0 while `rst_n`=0, and 1 from the first cycle after release.
- Memory array contents are not reset.
- Read latency is 1 cycle: `ram_addr` is sampled at edge N, and data is valid after edge N until edge N+1.
- `cpu_run` rises at the edge that accepts the last beat. `load_ready` falls at the same edge.
- Reset asserted mid-load: the loader aborts immediately. The partial image stays in the array; `prog_len` returns to 0 and a full reload is required.

## Configuration
- `KS_MEM_PROTECT_EN` defined:
  - In RUN, processor writes to addresses < `prog_len` are suppressed. Program words are read-only.
  - Each suppressed write sets `prot_fault`, which stays at 1 until reset.
- Not defined:
  - All processor writes in RUN are performed.
  - `prot_fault` is tied 0.

## Structure
- `k_and_s_pkg` additions:
  - `KS_ADDR_W`=5, `KS_DATA_W`=16, `KS_MEM_DEPTH`=32.
  - `ks_mem_state_t` enum {LOAD, RUN}.
- Sub-module `ks_ram_array`: single-port storage, with a synchronous read-first registered output and a write enable. The loader and processor muxes live in `ks_memory`.

## Test plan
- Reset, then stream 3 words 0x1111, 0x2222, 0x3333 with `load_last` on the third beat:
  - `load_ready`=1 throughout the load.
  - `cpu_run`=1 at the third accept edge.
  - `prog_len`=3.
  - Reads of addr 0/1/2 return the words one cycle after the address.
- Deassert `load_valid` between beats for 4 cycles: no spurious write, `load_ptr` holds, and the remaining beats land at the correct addresses.
- Stream 32 words without `load_last`:
  - RUN is entered after beat 32 and `prog_len`=32.
  - A 33rd `load_valid` is ignored and `load_ready`=0.
- In RUN:
  - Write 0xBEEF to addr 20, and read addr 20 in the same cycle: the old value is returned.
  - The next cycle returns 0xBEEF.
- With `KS_MEM_PROTECT_EN` and `prog_len`=3:
  - Write 0xDEAD to addr 1: addr 1 is unchanged and `prot_fault`=1.
  - Write to addr 5 succeeds.
  - Without the macro, the addr 1 write succeeds and `prot_fault`=0.
- Assert `rst_n`=0 after 2 of 5 beats:
  - All outputs reach their reset values asynchronously.
  - After release, the loader restarts at addr 0 and `prog_len`=0.

Source files
------------

// File: rtl/k_and_s_pkg.sv
// rtl/k_and_s_pkg.sv - K&S shared sizes and the memory loader state type
package k_and_s_pkg;

    localparam int KS_ADDR_W    = 5;
    localparam int KS_DATA_W    = 16;
    localparam int KS_MEM_DEPTH = 32;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } ks_mem_state_t;

endpackage

// File: rtl/ks_ram_array.sv
// rtl/ks_ram_array.sv - single-port word storage with registered read-first output
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (output register only)
//   we_i         write strobe for addr_i / wdata_i
//   addr_i       shared read/write address
//   wdata_i      write data
//   rd_en_i      when high, rdata_o captures mem[addr_i]; when low it holds
//   rdata_o      registered read data (old word on a same-address write)
module ks_ram_array #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Array contents are deliberately not reset so a partial image survives.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Non-blocking read of mem_q returns the pre-write word: read-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ks_memory.sv
// rtl/ks_memory.sv - K&S unified program/data memory with host boot loader
//
// Optional feature macro: KS_MEM_PROTECT_EN (write-protect loaded program words).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ram_addr, ram_wdata,
//   ram_write_enable           processor access (honoured only in RUN)
//   ram_rdata                  registered read data, 1-cycle latency, 0 in LOAD
//   load_valid, load_data,
//   load_last, load_ready      host image stream
//   cpu_run                    image loaded, processor may run
//   prog_len                   number of words loaded (0..DEPTH)
//   prot_fault                 sticky suppressed-write flag
module ks_memory
    import k_and_s_pkg::*;
#(
    parameter int DEPTH  = KS_MEM_DEPTH,
    parameter int ADDR_W = KS_ADDR_W,
    parameter int DATA_W = KS_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_write_enable,
    output logic [DATA_W-1:0] ram_rdata,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              cpu_run,
    output logic [ADDR_W:0]   prog_len,
    output logic              prot_fault
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ks_mem_state_t     state_q, state_d;
    logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic              ready_q, ready_d;

    logic              accept;
    logic              last_beat;
    logic              wr_blocked;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd_en;

    // ready_q is only ever high in LOAD, so it alone qualifies a beat.
    assign accept    = load_valid && ready_q;
    // A beat into the last slot ends the load even without load_last.
    assign last_beat = accept && (load_last || (load_ptr_q == LAST_ADDR));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            load_ptr_q <= '0;
            prog_len_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_ptr_q <= load_ptr_d;
            prog_len_q <= prog_len_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state logic; RUN is left only through reset.
    always_comb begin
        state_d    = state_q;
        load_ptr_d = load_ptr_q;
        prog_len_d = prog_len_q;
        if (state_q == LOAD && last_beat) begin
            state_d = RUN;
        end
        if (accept) begin
            prog_len_d = prog_len_q + 1'b1;
            if (load_ptr_q != LAST_ADDR) begin
                load_ptr_d = load_ptr_q + 1'b1;
            end
        end
        // Registered so load_ready stays low through reset and falls on the
        // same edge that accepts the final beat.
        ready_d = (state_d == LOAD);
    end

`ifdef KS_MEM_PROTECT_EN
    logic fault_q;

    assign wr_blocked = ({1'b0, ram_addr} < prog_len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (state_q == RUN && ram_write_enable && wr_blocked) begin
            fault_q <= 1'b1;
        end
    end

    assign prot_fault = fault_q;
`else
    assign wr_blocked = 1'b0;
    assign prot_fault = 1'b0;
`endif

    // Output logic: steer the single array port between loader and processor.
    always_comb begin
        cpu_run   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = load_ptr_q;
        mem_wdata = load_data;
        mem_rd_en = 1'b0;
        if (state_q == LOAD) begin
            mem_we = accept;
        end else begin
            cpu_run   = 1'b1;
            mem_addr  = ram_addr;
            mem_wdata = ram_wdata;
            mem_we    = ram_write_enable && !wr_blocked;
            mem_rd_en = 1'b1;
        end
    end

    ks_ram_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rd_en_i (mem_rd_en),
        .rdata_o (ram_rdata)
    );

    assign load_ready = ready_q;
    assign prog_len   = prog_len_q;

endmodule
